// File: rtl/argmax_scan.sv
// Snapshots NUM_CLASS signed results on START and scans them one word per clock for the largest.
// Optional ARGMAX_TOP2_EN also tracks the second-largest; when undefined, SECOND_* read as 0.
module argmax_scan #(
  parameter int NUM_CLASS = 46,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 6
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        START,
  input  logic [NUM_CLASS*DATA_W-1:0] RESULTS,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [IDX_W-1:0]            MAX_IDX,
  output logic [DATA_W-1:0]           MAX_VAL,
  output logic [IDX_W-1:0]            SECOND_IDX,
  output logic [DATA_W-1:0]           SECOND_VAL
);
  typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASS - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         cnt_q, cnt_d;
  logic                     load;
  logic                     scan_last;
  logic                     done_edge;
  logic signed [DATA_W-1:0] snap_q [NUM_CLASS];
  logic signed [DATA_W-1:0] word;

  logic [IDX_W-1:0]         max_idx_q, max_idx_d, max_idx_out_q;
  logic signed [DATA_W-1:0] max_val_q, max_val_d, max_val_out_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    word      = snap_q[cnt_q];
    scan_last = (cnt_q == LAST_IDX);
    done_edge = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (scan_last) begin
          done_edge = 1'b1;
          state_d   = FINISH;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      FINISH: begin
        // A START here restarts immediately, giving back-to-back scans.
        state_d = IDLE;
        if (START) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < NUM_CLASS; k++) snap_q[k] <= '0;
    end else if (load) begin
      for (int k = 0; k < NUM_CLASS; k++) snap_q[k] <= RESULTS[k*DATA_W +: DATA_W];
    end
  end

  // Strict compare: equal values never displace the earlier (lower) index.
  always_comb begin
    max_idx_d = max_idx_q;
    max_val_d = max_val_q;
    if (state_q == SCAN) begin
      if (cnt_q == '0) begin
        max_idx_d = '0;
        max_val_d = word;
      end else if (word > max_val_q) begin
        max_idx_d = cnt_q;
        max_val_d = word;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      max_idx_q     <= '0;
      max_val_q     <= '0;
      max_idx_out_q <= '0;
      max_val_out_q <= '0;
    end else begin
      max_idx_q <= max_idx_d;
      max_val_q <= max_val_d;
      if (done_edge) begin
        max_idx_out_q <= max_idx_d;
        max_val_out_q <= max_val_d;
      end
    end
  end

  assign BUSY    = (state_q != IDLE);
  assign DONE    = (state_q == FINISH);
  assign MAX_IDX = max_idx_out_q;
  assign MAX_VAL = max_val_out_q;

`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0]         sec_idx_q, sec_idx_d, sec_idx_out_q;
  logic signed [DATA_W-1:0] sec_val_q, sec_val_d, sec_val_out_q;
  logic                     sec_vld_q, sec_vld_d;

  always_comb begin
    sec_idx_d = sec_idx_q;
    sec_val_d = sec_val_q;
    sec_vld_d = sec_vld_q;
    if (state_q == SCAN) begin
      if (cnt_q == '0) begin
        sec_vld_d = 1'b0;
      end else if (word > max_val_q) begin
        sec_idx_d = max_idx_q;
        sec_val_d = max_val_q;
        sec_vld_d = 1'b1;
      end else if (!sec_vld_q || (word > sec_val_q)) begin
        sec_idx_d = cnt_q;
        sec_val_d = word;
        sec_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sec_idx_q     <= '0;
      sec_val_q     <= '0;
      sec_vld_q     <= 1'b0;
      sec_idx_out_q <= '0;
      sec_val_out_q <= '0;
    end else begin
      sec_idx_q <= sec_idx_d;
      sec_val_q <= sec_val_d;
      sec_vld_q <= sec_vld_d;
      if (done_edge) begin
        sec_idx_out_q <= sec_idx_d;
        sec_val_out_q <= sec_val_d;
      end
    end
  end

  assign SECOND_IDX = sec_idx_out_q;
  assign SECOND_VAL = sec_val_out_q;
`else
  assign SECOND_IDX = '0;
  assign SECOND_VAL = '0;
`endif

endmodule

// File: tb/tb_argmax_scan.sv
// Self-checking bench for argmax_scan: edge-count behavioural model plus directed scenarios.
module tb_argmax_scan;
  localparam int N  = 46;
  localparam int DW = 32;
  localparam int IW = 6;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          START = 1'b0;
  logic [N*DW-1:0] RESULTS = '0;
  logic          BUSY, DONE;
  logic [IW-1:0] MAX_IDX, SECOND_IDX;
  logic [DW-1:0] MAX_VAL, SECOND_VAL;

  int checks = 0;
  int failures = 0;

  argmax_scan #(.NUM_CLASS(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .RESULTS(RESULTS),
    .BUSY(BUSY), .DONE(DONE), .MAX_IDX(MAX_IDX), .MAX_VAL(MAX_VAL),
    .SECOND_IDX(SECOND_IDX), .SECOND_VAL(SECOND_VAL)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference ranking: plain signed search, lowest index wins ties.
  function automatic int max_index(input logic [N*DW-1:0] r);
    logic signed [DW-1:0] w [N];
    int mi;
    for (int k = 0; k < N; k++) w[k] = r[k*DW +: DW];
    mi = 0;
    for (int k = 1; k < N; k++) if (w[k] > w[mi]) mi = k;
    return mi;
  endfunction

  function automatic int second_index(input logic [N*DW-1:0] r, input int mi);
    logic signed [DW-1:0] w [N];
    int si;
    for (int k = 0; k < N; k++) w[k] = r[k*DW +: DW];
    si = (mi == 0) ? 1 : 0;
    for (int k = 0; k < N; k++) if (k != mi && w[k] > w[si]) si = k;
    return si;
  endfunction

  // Model state in terms of edge numbers: a scan accepted at edge a finishes at a+N.
  int e = 0;
  int a = 0;
  bit have = 1'b0;
  bit m_busy = 1'b0, m_done = 1'b0;
  int m_mi = 0, m_si = 0, p_mi = 0, p_si = 0;
  logic [DW-1:0] m_mv = '0, m_sv = '0, p_mv = '0, p_sv = '0;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      have   <= 1'b0;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_mi   <= 0;
      m_mv   <= '0;
      m_si   <= 0;
      m_sv   <= '0;
    end else begin
      e      <= e + 1;
      m_done <= have && (e + 1 == a + N);
      if (have && (e + 1 == a + N)) begin
        m_mi <= p_mi;
        m_mv <= p_mv;
`ifdef ARGMAX_TOP2_EN
        m_si <= p_si;
        m_sv <= p_sv;
`endif
      end
      if (START && (!have || (e + 1 > a + N))) begin
        have   <= 1'b1;
        a      <= e + 1;
        p_mi   <= max_index(RESULTS);
        p_mv   <= RESULTS[max_index(RESULTS)*DW +: DW];
        p_si   <= second_index(RESULTS, max_index(RESULTS));
        p_sv   <= RESULTS[second_index(RESULTS, max_index(RESULTS))*DW +: DW];
        m_busy <= 1'b1;
      end else begin
        m_busy <= have && (e + 1 <= a + N);
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("busy", BUSY, m_busy);
      chk("done", DONE, m_done);
      chk("max_idx", MAX_IDX, m_mi);
      chk("max_val", MAX_VAL, m_mv);
      chk("second_idx", SECOND_IDX, m_si);
      chk("second_val", SECOND_VAL, m_sv);
    end
  end

  task automatic fill(input logic [DW-1:0] v);
    for (int k = 0; k < N; k++) RESULTS[k*DW +: DW] = v;
  endtask

  task automatic pulse(output int s_o);
    START = 1'b1;
    s_o = e + 1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Called at the negedge after the START edge; returns at the first negedge with BUSY low.
  task automatic wait_scan(output int de, output int bn, output int dn);
    de = -1;
    bn = 0;
    dn = 0;
    for (int i = 0; i < 200; i++) begin
      if (!BUSY) break;
      bn++;
      if (DONE) begin
        dn++;
        de = e;
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected self-finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, de, bn, dn, d1, ndone;

    #1 RESET = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    repeat (20) @(negedge CLK);
    chk("idle_busy", BUSY, 0);
    chk("idle_done", DONE, 0);
    chk("idle_max_idx", MAX_IDX, 0);
    chk("idle_max_val", MAX_VAL, 0);

    for (int k = 0; k < N; k++) RESULTS[k*DW +: DW] = DW'(k * 10);
    RESULTS[37*DW +: DW] = 32'd1000;
    pulse(s);
    wait_scan(de, bn, dn);
    chk("peak_latency", de - s, 46);
    chk("peak_busy_cycles", bn, 47);
    chk("peak_done_count", dn, 1);
    chk("peak_idx", MAX_IDX, 37);
    chk("peak_val", MAX_VAL, 1000);
`ifdef ARGMAX_TOP2_EN
    chk("peak_second_idx", SECOND_IDX, 45);
    chk("peak_second_val", SECOND_VAL, 450);
`else
    chk("peak_second_idx_off", SECOND_IDX, 0);
`endif

    fill(32'hFFFF_FFF0);
    RESULTS[5*DW +: DW]  = 32'hFFFF_FFFF;
    RESULTS[20*DW +: DW] = 32'hFFFF_FFFF;
    pulse(s);
    wait_scan(de, bn, dn);
    chk("tie_idx", MAX_IDX, 5);
    chk("tie_val", MAX_VAL, 32'hFFFF_FFFF);
`ifdef ARGMAX_TOP2_EN
    chk("tie_second_idx", SECOND_IDX, 20);
    chk("tie_second_val", SECOND_VAL, 32'hFFFF_FFFF);
`endif

    fill(32'h8000_0000);
    pulse(s);
    wait_scan(de, bn, dn);
    chk("minval_latency", de - s, 46);
    chk("minval_idx", MAX_IDX, 0);
    chk("minval_val", MAX_VAL, 32'h8000_0000);

    fill(32'd0);
    RESULTS[2*DW +: DW] = 32'd500;
    pulse(s);
    for (int i = 0; i < 100 && e < s + 9; i++) @(negedge CLK);
    RESULTS[40*DW +: DW] = 32'd9000;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_scan(de, bn, dn);
    chk("snap_latency", de - s, 46);
    chk("snap_done_count", dn, 1);
    chk("snap_idx", MAX_IDX, 2);
    chk("snap_val", MAX_VAL, 500);
    repeat (5) @(negedge CLK);
    chk("snap_no_rescan", BUSY, 0);

    fill(32'd0);
    RESULTS[10*DW +: DW] = 32'd3;
    pulse(s);
    for (int i = 0; i < 100 && !DONE; i++) @(negedge CLK);
    d1 = e;
    chk("b2b_first_latency", d1 - s, 46);
    fill(32'd0);
    RESULTS[44*DW +: DW] = 32'd7;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    chk("b2b_busy_kept", BUSY, 1);
    chk("b2b_hold_idx", MAX_IDX, 10);
    chk("b2b_hold_val", MAX_VAL, 3);
    wait_scan(de, bn, dn);
    chk("b2b_period", de - d1, 47);
    chk("b2b_done_count", dn, 1);
    chk("b2b_idx", MAX_IDX, 44);
    chk("b2b_val", MAX_VAL, 7);

    fill(32'd0);
    RESULTS[30*DW +: DW] = 32'd99;
    pulse(s);
    for (int i = 0; i < 100 && e < s + 19; i++) @(negedge CLK);
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_async_busy", BUSY, 0);
    chk("rst_async_done", DONE, 0);
    chk("rst_async_idx", MAX_IDX, 0);
    chk("rst_async_val", MAX_VAL, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    pulse(s);
    wait_scan(de, bn, dn);
    chk("rst_fresh_latency", de - s, 46);
    chk("rst_fresh_idx", MAX_IDX, 30);
    chk("rst_fresh_val", MAX_VAL, 99);

    repeat (3) @(negedge CLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
